// File: rtl/nexys4_pkg.sv
// Shared constants and types for the Nexys4 logic-analyzer board top.
// Contents: baud divider default, FIFO depth, banner ROM, engine states,
// command codes, and a banner ROM lookup helper.
package nexys4_pkg;

  localparam int BAUD_DIV_DEF = 54;  // 100 MHz / (16 * 115200), rounded
  localparam int FIFO_DEPTH   = 16;
  localparam int MSG_LEN      = 13;

  localparam logic [7:0] CMD_SNAP = 8'h3F;

  // "HELLO World\r\n"; byte 0 sits in the most significant position.
  localparam logic [MSG_LEN*8-1:0] BANNER = {"HELLO World", 8'h0D, 8'h0A};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MSG,
    ST_SNAP
  } eng_state_e;

  function automatic logic [7:0] banner_byte(input logic [3:0] idx);
    return BANNER[8*(MSG_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/sync_fifo16.sv
// 16-entry first-word-fall-through byte FIFO shared by the UART TX and RX.
// Ports: clk_i, rst_i (sync, clears pointers), wr_i/din_i (write, dropped
// when full), rd_i (pop, ignored when empty), dout_o (head entry),
// full_o, half_full_o (8 or more entries), present_o (not empty).
module sync_fifo16
  import nexys4_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       half_full_o,
  output logic       present_o
);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [3:0] wr_ptr_q, rd_ptr_q;
  logic [4:0] count_q;
  logic       do_wr, do_rd;

  assign full_o      = (count_q == 5'(FIFO_DEPTH));
  assign half_full_o = (count_q >= 5'(FIFO_DEPTH/2));
  assign present_o   = (count_q != 5'd0);
  assign dout_o      = mem_q[rd_ptr_q];
  assign do_wr       = wr_i && !full_o;
  assign do_rd       = rd_i && present_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 4'd1;
      count_q <= count_q + {4'd0, do_wr} - {4'd0, do_rd};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx6.sv
// UART receiver, 8N1, LSB first, 16 baud ticks per bit, with 16-byte FIFO.
// Ports: clk, buffer_reset (sync, abandons frame and empties FIFO),
// en_16_x_baud (16x baud tick), serial_in (already synchronized, idle high),
// data_out/buffer_read (FIFO head and pop), buffer_full, buffer_half_full,
// buffer_data_present. Frames with a low stop bit are discarded.
module uart_rx6 (
  input  logic       clk,
  input  logic       buffer_reset,
  input  logic       en_16_x_baud,
  input  logic       serial_in,
  output logic [7:0] data_out,
  input  logic       buffer_read,
  output logic       buffer_full,
  output logic       buffer_half_full,
  output logic       buffer_data_present
);
  logic       prev_q, busy_q;
  logic [3:0] tick_q, bit_q;
  logic [7:0] shift_q;
  logic       mid, fifo_wr;

  // tick_q wraps every 16 ticks, so tick 8 is mid-bit for every bit of the frame.
  assign mid     = en_16_x_baud && busy_q && (tick_q == 4'd8);
  assign fifo_wr = mid && (bit_q == 4'd9) && serial_in;

  sync_fifo16 u_fifo (
    .clk_i      (clk),
    .rst_i      (buffer_reset),
    .wr_i       (fifo_wr),
    .rd_i       (buffer_read),
    .din_i      (shift_q),
    .dout_o     (data_out),
    .full_o     (buffer_full),
    .half_full_o(buffer_half_full),
    .present_o  (buffer_data_present)
  );

  always_ff @(posedge clk) begin
    if (buffer_reset) begin
      prev_q <= 1'b1;
      busy_q <= 1'b0;
      tick_q <= 4'd0;
      bit_q  <= 4'd0;
    end else if (en_16_x_baud) begin
      prev_q <= serial_in;
      if (!busy_q) begin
        if (prev_q && !serial_in) begin
          busy_q <= 1'b1;
          tick_q <= 4'd1;
          bit_q  <= 4'd0;
        end
      end else begin
        tick_q <= tick_q + 4'd1;
        if (tick_q == 4'd8) begin
          // A start bit that is high again at mid-bit was a glitch.
          if ((bit_q == 4'd0) && serial_in) busy_q <= 1'b0;
          else if (bit_q == 4'd9)           busy_q <= 1'b0;
          else                              bit_q  <= bit_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mid && (bit_q != 4'd0) && (bit_q != 4'd9)) shift_q <= {serial_in, shift_q[7:1]};
  end

endmodule

// File: rtl/uart_tx6.sv
// UART transmitter, 8N1, LSB first, 16 baud ticks per bit, with 16-byte FIFO.
// Ports: clk, buffer_reset (sync, aborts frame and empties FIFO),
// en_16_x_baud (16x baud tick), data_in/buffer_write (FIFO write),
// serial_out (idle high), buffer_full, buffer_half_full, buffer_data_present.
module uart_tx6 (
  input  logic       clk,
  input  logic       buffer_reset,
  input  logic       en_16_x_baud,
  input  logic [7:0] data_in,
  input  logic       buffer_write,
  output logic       serial_out,
  output logic       buffer_full,
  output logic       buffer_half_full,
  output logic       buffer_data_present
);
  logic [7:0] fifo_dout;
  logic       fifo_rd;
  logic       busy_q;
  logic [3:0] tick_q, bit_q;
  logic [8:0] shift_q;
  logic       txd_q;
  logic       bit_end, frame_end;

  sync_fifo16 u_fifo (
    .clk_i      (clk),
    .rst_i      (buffer_reset),
    .wr_i       (buffer_write),
    .rd_i       (fifo_rd),
    .din_i      (data_in),
    .dout_o     (fifo_dout),
    .full_o     (buffer_full),
    .half_full_o(buffer_half_full),
    .present_o  (buffer_data_present)
  );

  assign serial_out = txd_q;
  assign bit_end    = busy_q && (tick_q == 4'd15);
  assign frame_end  = bit_end && (bit_q == 4'd9);
  // Load straight after a stop bit too, so back-to-back frames are exactly 160 ticks.
  assign fifo_rd    = en_16_x_baud && buffer_data_present && (!busy_q || frame_end);

  // bit_q: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (buffer_reset) begin
      busy_q <= 1'b0;
      tick_q <= 4'd0;
      bit_q  <= 4'd0;
      txd_q  <= 1'b1;
    end else if (en_16_x_baud) begin
      if (fifo_rd) begin
        busy_q <= 1'b1;
        tick_q <= 4'd0;
        bit_q  <= 4'd0;
        txd_q  <= 1'b0;
      end else if (frame_end) begin
        busy_q <= 1'b0;
        txd_q  <= 1'b1;
      end else if (busy_q) begin
        tick_q <= tick_q + 4'd1;
        if (bit_end) begin
          bit_q <= bit_q + 4'd1;
          txd_q <= shift_q[0];
        end
      end
    end
  end

  // Stop bit rides in the top of the shifter and reaches bit 0 after the data.
  always_ff @(posedge clk) begin
    if (fifo_rd) shift_q <= {1'b1, fifo_dout};
    else if (en_16_x_baud && bit_end) shift_q <= {1'b1, shift_q[8:1]};
  end

endmodule

// File: rtl/nexys4_fpga.sv
// Nexys4 board top: USB-UART bridge to a small command/message engine.
// A rising edge on sw[1] or btnC queues "HELLO World\r\n"; received bytes
// are echoed and shown on led[7:0]; '?' returns the JA then JB probe bytes.
// Ports: clk (100 MHz), btnCpuReset (sync, active-high), btnC (trigger),
// btnW/E/N/S (unused), sw[15:0] (sw[1] trigger, sw[15:8] to led[15:8]),
// led[15:0], uart_rxd/uart_txd (8N1 serial), JA/JB (probe inputs).
module nexys4_fpga
  import nexys4_pkg::*;
#(
  parameter int TB_MODE  = 0,
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        btnW,
  input  logic        btnE,
  input  logic        btnN,
  input  logic        btnS,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic [15:0] led,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [7:0]  JA,
  input  logic [7:0]  JB
);
  logic        rst;
  logic [33:0] sync1_q, sync2_q;
  logic [15:0] sw_s;
  logic        btnc_s, rxd_s;
  logic [7:0]  ja_s, jb_s;
  logic [1:0]  trig_prev_q;
  logic        trig_edge;
  logic [15:0] baud_cnt_q;
  logic        baud_tick_q, en_16;
  logic        tx_wr, tx_full, tx_half, tx_present;
  logic [7:0]  tx_din;
  logic        rx_rd, rx_full, rx_half, rx_present;
  logic [7:0]  rx_dout;
  eng_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [7:0]  led_lo_q, led_lo_d;
  logic [7:0]  led_hi_q;
  logic        unused_ok;

  assign rst = btnCpuReset;

  // Synchronizers and trigger history run through reset, so a level already
  // high when reset is released does not count as an edge.
  always_ff @(posedge clk) begin
    sync1_q     <= {uart_rxd, JB, JA, btnC, sw};
    sync2_q     <= sync1_q;
    trig_prev_q <= {btnc_s, sw_s[1]};
  end

  assign sw_s      = sync2_q[15:0];
  assign btnc_s    = sync2_q[16];
  assign ja_s      = sync2_q[24:17];
  assign jb_s      = sync2_q[32:25];
  assign rxd_s     = sync2_q[33];
  assign trig_edge = |({btnc_s, sw_s[1]} & ~trig_prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q  <= 16'd0;
      baud_tick_q <= 1'b0;
    end else if (baud_cnt_q == 16'(BAUD_DIV-1)) begin
      baud_cnt_q  <= 16'd0;
      baud_tick_q <= 1'b1;
    end else begin
      baud_cnt_q  <= baud_cnt_q + 16'd1;
      baud_tick_q <= 1'b0;
    end
  end

  assign en_16 = (TB_MODE != 0) ? 1'b1 : baud_tick_q;

  uart_tx6 u_tx (
    .clk                (clk),
    .buffer_reset       (rst),
    .en_16_x_baud       (en_16),
    .data_in            (tx_din),
    .buffer_write       (tx_wr),
    .serial_out         (uart_txd),
    .buffer_full        (tx_full),
    .buffer_half_full   (tx_half),
    .buffer_data_present(tx_present)
  );

  uart_rx6 u_rx (
    .clk                (clk),
    .buffer_reset       (rst),
    .en_16_x_baud       (en_16),
    .serial_in          (rxd_s),
    .data_out           (rx_dout),
    .buffer_read        (rx_rd),
    .buffer_full        (rx_full),
    .buffer_half_full   (rx_half),
    .buffer_data_present(rx_present)
  );

  // A trigger arriving while busy is held one deep; later ones are lost.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    led_lo_d = led_lo_q;
    tx_wr    = 1'b0;
    tx_din   = rx_dout;
    rx_rd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_edge || pend_q) begin
          state_d = ST_MSG;
          idx_d   = 4'd0;
          pend_d  = 1'b0;
        end else if (rx_present && !tx_full) begin
          rx_rd    = 1'b1;
          led_lo_d = rx_dout;
          if (rx_dout == CMD_SNAP) begin
            state_d = ST_SNAP;
            idx_d   = 4'd0;
          end else begin
            tx_wr = 1'b1;
          end
        end
      end
      ST_MSG: begin
        if (trig_edge) pend_d = 1'b1;
        tx_din = banner_byte(idx_q);
        if (!tx_full) begin
          tx_wr = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(MSG_LEN-1)) state_d = ST_IDLE;
        end
      end
      ST_SNAP: begin
        if (trig_edge) pend_d = 1'b1;
        tx_din = idx_q[0] ? jb_s : ja_s;
        if (!tx_full) begin
          tx_wr = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q[0]) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      pend_q   <= 1'b0;
      led_lo_q <= 8'd0;
      led_hi_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      led_lo_q <= led_lo_d;
      led_hi_q <= sw_s[15:8];
    end
  end

  assign led = {led_hi_q, led_lo_q};

  assign unused_ok = ^{btnW, btnE, btnN, btnS, sw_s[7:2], sw_s[0],
                       tx_half, tx_present, rx_full, rx_half};

endmodule

// File: tb/tb_nexys4_fpga.sv
// Bench for nexys4_fpga in TB_MODE: an external uart_rx6 decodes uart_txd,
// and every decoded byte is checked against a queue of expected bytes that
// the stimulus pushes when it provokes them.
module tb_nexys4_fpga;

  logic        clk = 1'b0;
  logic        btnCpuReset;
  logic        btnW, btnE, btnN, btnS, btnC;
  logic [15:0] sw;
  logic [15:0] led;
  logic        uart_rxd, uart_txd;
  logic [7:0]  JA, JB;

  logic [7:0]  mon_dout;
  logic        mon_rd = 1'b0;
  logic        mon_full, mon_half, mon_present;

  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  int          mon_cnt   = 0;
  int          txd_lows  = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          base_cnt, base_lows;

  logic [7:0]  banner [13] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57,
                              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  nexys4_fpga #(.TB_MODE(1)) dut (
    .clk        (clk),
    .btnCpuReset(btnCpuReset),
    .btnW       (btnW),
    .btnE       (btnE),
    .btnN       (btnN),
    .btnS       (btnS),
    .btnC       (btnC),
    .sw         (sw),
    .led        (led),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .JA         (JA),
    .JB         (JB)
  );

  uart_rx6 mon (
    .clk                (clk),
    .buffer_reset       (btnCpuReset),
    .en_16_x_baud       (1'b1),
    .serial_in          (uart_txd),
    .data_out           (mon_dout),
    .buffer_read        (mon_rd),
    .buffer_full        (mon_full),
    .buffer_half_full   (mon_half),
    .buffer_data_present(mon_present)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      tick(16);
    end
    uart_rxd = 1'b1;
    tick(4);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_banner();
    for (int i = 0; i < 13; i++) exp_q.push_back(banner[i]);
  endtask

  // Scoreboard: pop each decoded byte and compare against the expected queue.
  always @(negedge clk) begin
    if (mon_present) begin
      mon_cnt++;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("rx_byte", {24'd0, mon_dout}, {24'd0, mon_exp});
      end else begin
        check_eq("rx_spurious", {24'd0, mon_dout}, 32'h100);
      end
      mon_rd = 1'b1;
    end else begin
      mon_rd = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!uart_txd) txd_lows++;
  end

  initial begin
    btnCpuReset = 1'b1;
    btnW = 1'b0; btnE = 1'b0; btnN = 1'b0; btnS = 1'b0; btnC = 1'b0;
    sw = 16'h0000; uart_rxd = 1'b1; JA = 8'h00; JB = 8'h00;

    // Reset and quiet line
    tick(10);
    btnCpuReset = 1'b0;
    tick(1);
    check_eq("rst_txd", {31'd0, uart_txd}, 32'd1);
    check_eq("rst_led", {16'd0, led}, 32'h0000);
    base_lows = txd_lows;
    base_cnt  = mon_cnt;
    tick(1000);
    check_eq("idle_txd_lows", 32'(txd_lows - base_lows), 32'd0);
    check_eq("idle_rx_cnt", 32'(mon_cnt - base_cnt), 32'd0);

    // Switch mirror
    sw = 16'hC300;
    tick(4);
    check_eq("led_hi", {24'd0, led[15:8]}, 32'hC3);

    // Banner from sw[1]
    base_cnt = mon_cnt;
    push_banner();
    sw = 16'hC302;
    wait_drain(2100, "banner_drain");
    tick(20);
    check_eq("banner_cnt", 32'(mon_cnt - base_cnt), 32'd13);
    sw = 16'hC300;
    tick(20);

    // Echo
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    wait_drain(400, "echo_drain");
    check_eq("echo_led", {24'd0, led[7:0]}, 32'h11);

    // Probe snapshot
    JA = 8'hA5; JB = 8'h3C;
    tick(4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'h3F, 1'b1);
    wait_drain(600, "snap_drain");
    check_eq("snap_led", {24'd0, led[7:0]}, 32'h3F);
    tick(20);

    // Two btnC edges while the banner is being queued: one latched, one lost
    base_cnt = mon_cnt;
    push_banner();
    push_banner();
    sw = 16'hC302;
    tick(4);
    btnC = 1'b1; tick(2);
    btnC = 1'b0; tick(2);
    btnC = 1'b1; tick(2);
    btnC = 1'b0;
    wait_drain(4400, "double_drain");
    tick(400);
    check_eq("double_cnt", 32'(mon_cnt - base_cnt), 32'd26);
    sw = 16'hC300;
    tick(20);

    // Framing error is not echoed
    base_cnt  = mon_cnt;
    base_lows = txd_lows;
    send_byte(8'h55, 1'b0);
    tick(300);
    check_eq("ferr_cnt", 32'(mon_cnt - base_cnt), 32'd0);
    check_eq("ferr_txd_lows", 32'(txd_lows - base_lows), 32'd0);
    check_eq("ferr_led", {24'd0, led[7:0]}, 32'h3F);

    // Reset in the middle of a banner frame
    push_banner();
    btnC = 1'b1; tick(2);
    btnC = 1'b0;
    tick(600);
    for (int i = 0; i < 200; i++) begin
      if (!uart_txd) break;
      tick(1);
    end
    check_eq("rst_find_low", {31'd0, uart_txd}, 32'd0);
    btnCpuReset = 1'b1;
    tick(1);
    check_eq("midrst_txd", {31'd0, uart_txd}, 32'd1);
    check_eq("midrst_led", {16'd0, led}, 32'h0000);
    exp_q.delete();
    tick(5);
    btnCpuReset = 1'b0;
    tick(2);
    base_cnt  = mon_cnt;
    base_lows = txd_lows;
    tick(1000);
    check_eq("post_rst_lows", 32'(txd_lows - base_lows), 32'd0);
    check_eq("post_rst_cnt", 32'(mon_cnt - base_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nexys4_fpga.md
# nexys4_fpga

Board top for the Nexys4 logic-analyzer kernel. It bridges the USB-UART to a small command/message engine. A `sw[1]` or `btnC` rising edge queues the ASCII banner "HELLO World\r\n" on the UART transmitter. Received bytes are echoed back and latched on the LEDs, and `?` returns a raw snapshot of the JA/JB probe ports. `TB_MODE` collapses the baud generator so simulation runs at one 16x-baud tick per clock.

## Interface
- `TB_MODE`, default 0: when 1, `en_16_x_baud` is asserted every clock; when 0, it pulses once every `BAUD_DIV` clocks.
- `BAUD_DIV`, default 54: 100 MHz / (16 × 115200), rounded.
- `clk` input, 1 bit: 100 MHz system clock; the only clock.
- `btnCpuReset` input, 1 bit: synchronous, active-high reset.
- `btnW`, `btnE`, `btnN`, `btnS` input, 1 bit each: reserved, ignored.
- `btnC` input, 1 bit: banner trigger, rising edge.
- `sw` input, 16 bits: `sw[1]` is the banner trigger (rising edge); `sw[15:8]` is mirrored to `led[15:8]`.
- `led` output, 16 bits: `[7:0]` holds the last received byte; `[15:8]` holds the registered `sw[15:8]`.
- `uart_rxd` input, 1 bit: serial data into the FPGA, idle high.
- `uart_txd` output, 1 bit: serial data out of the FPGA, idle high.
- `JA`, `JB` input, 8 bits each: probe ports, sampled on a `?` command.

## Operation
- Reset values: `led` = 0, `uart_txd` = 1, both FIFOs empty, engine IDLE, edge detectors cleared. During reset `sw` and `btnC` history still loads, so a level already high at reset release does not trigger.
- Inputs `sw`, `btnC`, `JA`, `JB` and `uart_rxd` each pass through a 2-flop synchronizer. There is no debounce in either mode.
- UART format: 8N1, LSB first, 16 baud ticks per bit.
- The transmitter `uart_tx6` has a 16-entry FIFO. Writing when the FIFO is full drops the byte; the engine never does this.
- The receiver `uart_rx6` has a 16-entry FIFO:
  - It detects a start bit on a falling edge, re-checks the line at tick 8 (mid-bit), then samples each bit at its mid-bit.
  - A stop bit of 0 discards the byte (framing error).
  - A byte arriving while the FIFO is full is dropped.
- Engine states:
  - IDLE:
    - Trigger edge pending → MSG, index 0.
    - Otherwise, RX FIFO not empty and TX FIFO not full → pop the RX byte, latch it on `led[7:0]`, and write it to the TX FIFO.
    - If that byte is 0x3F, go to SNAP instead of writing it.
  - MSG: writes ROM[index] whenever the TX FIFO is not full; the ROM is 13 bytes. After index 12 it returns to IDLE.
  - SNAP: writes the synchronized `JA`, then `JB`, one byte per non-full cycle, then returns to IDLE.
- A trigger edge during MSG or SNAP is latched, one deep, and served on return to IDLE. Further edges are discarded.
- Simultaneous trigger edge and RX data in IDLE: the trigger wins.

## Timing
- Trigger to first TX FIFO write: 3 clocks (2-flop synchronizer plus edge register).
- TX FIFO write to start bit on `uart_txd`: at most 1 baud tick.
- One frame is 160 baud ticks, i.e. 160 clocks in `TB_MODE`.
- The full banner takes 13 × 160 = 2080 clocks in `TB_MODE`.
- RX stop-bit sample to FIFO data present: 1 clock.
- `led[7:0]` updates 1 clock after the pop.
- Reset asserted mid-frame aborts the frame within 1 clock: `uart_txd` returns to 1 and both FIFOs clear.

## Structure
- Package `nexys4_pkg`:
  - `BAUD_DIV` default
  - FIFO depth (16)
  - the banner ROM constant (13 × 8 bits)
  - engine state enum (IDLE, MSG, SNAP)
  - command code `CMD_SNAP` = 8'h3F
- Sub-modules: `uart_tx6` and `uart_rx6` with the ports `clk`, `buffer_reset`, `en_16_x_baud`, `data_in` / `data_out`, `buffer_write` / `buffer_read`, `serial_in` / `serial_out`, `buffer_full`, `buffer_half_full` (at 8 or more entries), `buffer_data_present`. Both share one `sync_fifo16` sub-module.

## Test plan
- Hold `btnCpuReset`=1 for 10 clocks, then release → `uart_txd`=1, `led`=0x0000, no UART activity for 1000 clocks.
- Raise `sw[1]`, `TB_MODE`=1, with an external `uart_rx6` attached → it decodes "HELLO World\r\n" (0x48 … 0x0A), 13 bytes, finishing within 2100 clocks.
- Send 0x11 into `uart_rxd` → 0x11 echoed on `uart_txd`, `led[7:0]`=0x11.
- Set `JA`=0xA5 and `JB`=0x3C, then send 0x3F → `uart_txd` carries 0xA5 then 0x3C; `led[7:0]`=0x3F.
- Pulse `btnC` twice during a banner → exactly two banners total (26 bytes). Send a frame with stop bit 0 → nothing is echoed.
- Assert reset mid-banner → `uart_txd` goes high within 1 clock; after release, no residual bytes are sent.
